// File: rtl/id_ex_operandos.sv
// ID/EX pipeline register with operand forwarding, ALU input selection,
// load-use hazard detection and a saturating bubble counter.
module id_ex_operandos (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ID_VALID,
  input  logic [31:0] ID_PC,
  input  logic [31:0] ID_RS1_DATA,
  input  logic [31:0] ID_RS2_DATA,
  input  logic [31:0] ID_IMM,
  input  logic [4:0]  ID_RS1,
  input  logic [4:0]  ID_RS2,
  input  logic [4:0]  ID_RD,
  input  logic [3:0]  ID_ALU_CTRL,
  input  logic [1:0]  ID_ALUSRC_A,
  input  logic        ID_ALUSRC_B,
  input  logic        ID_REG_WRITE,
  input  logic        ID_MEM_READ,
  input  logic        ID_MEM_WRITE,
  input  logic [4:0]  EXMEM_RD,
  input  logic        EXMEM_REG_WRITE,
  input  logic [31:0] EXMEM_RESULT,
  input  logic [4:0]  MEMWB_RD,
  input  logic        MEMWB_REG_WRITE,
  input  logic [31:0] MEMWB_DATA,
  input  logic        HOLD,
  input  logic        FLUSH,
  output logic [31:0] X,
  output logic [31:0] Y,
  output logic [3:0]  CONTROL,
  output logic        EX_VALID,
  output logic [31:0] EX_PC,
  output logic [4:0]  EX_RD,
  output logic        EX_REG_WRITE,
  output logic        EX_MEM_READ,
  output logic        EX_MEM_WRITE,
  output logic [31:0] EX_STORE_DATA,
  output logic        LOAD_USE_HAZARD,
  output logic [15:0] BUBBLE_CNT
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_ctrl;
    logic [1:0]  alusrc_a;
    logic        alusrc_b;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } ex_regs_t;

  ex_regs_t    ex_q, ex_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic        load_use;
  logic [31:0] rs1_fwd, rs2_fwd;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // x0 never forwards; the newer EX/MEM result beats MEM/WB
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  rs,
    input logic [31:0] rf_data,
    input logic [4:0]  exmem_rd,
    input logic        exmem_wr,
    input logic [31:0] exmem_val,
    input logic [4:0]  memwb_rd,
    input logic        memwb_wr,
    input logic [31:0] memwb_val
  );
    if (exmem_wr && (exmem_rd != 5'd0) && (exmem_rd == rs)) begin
      return exmem_val;
    end else if (memwb_wr && (memwb_rd != 5'd0) && (memwb_rd == rs)) begin
      return memwb_val;
    end else begin
      return rf_data;
    end
  endfunction

  // Conservative load-use check against the load sitting in EX
  always_comb begin
    load_use = ID_VALID && ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
               ((ID_RS1 == ex_q.rd) || (ID_RS2 == ex_q.rd));
  end

  // Next-state selection: reset > flush > hold > hazard bubble > capture
  always_comb begin
    ex_d         = ex_q;
    bubble_cnt_d = bubble_cnt_q;
    if (RST) begin
      ex_d         = '0;
      bubble_cnt_d = 16'd0;
    end else if (FLUSH) begin
      ex_d = '0;
    end else if (HOLD) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d         = '0;
      bubble_cnt_d = sat_inc(bubble_cnt_q);
    end else begin
      ex_d.valid     = ID_VALID;
      ex_d.pc        = ID_PC;
      ex_d.rs1_data  = ID_RS1_DATA;
      ex_d.rs2_data  = ID_RS2_DATA;
      ex_d.imm       = ID_IMM;
      ex_d.rs1       = ID_RS1;
      ex_d.rs2       = ID_RS2;
      ex_d.rd        = ID_RD;
      ex_d.alu_ctrl  = ID_ALU_CTRL;
      ex_d.alusrc_a  = ID_ALUSRC_A;
      ex_d.alusrc_b  = ID_ALUSRC_B;
      ex_d.reg_write = ID_REG_WRITE;
      ex_d.mem_read  = ID_MEM_READ;
      ex_d.mem_write = ID_MEM_WRITE;
    end
  end

  // Pipeline state registers
  always_ff @(posedge CLK) begin
    ex_q         <= ex_d;
    bubble_cnt_q <= bubble_cnt_d;
  end

  // Operand forwarding and ALU input selection
  always_comb begin
    rs1_fwd = fwd_sel(ex_q.rs1, ex_q.rs1_data, EXMEM_RD, EXMEM_REG_WRITE, EXMEM_RESULT,
                      MEMWB_RD, MEMWB_REG_WRITE, MEMWB_DATA);
    rs2_fwd = fwd_sel(ex_q.rs2, ex_q.rs2_data, EXMEM_RD, EXMEM_REG_WRITE, EXMEM_RESULT,
                      MEMWB_RD, MEMWB_REG_WRITE, MEMWB_DATA);
    case (ex_q.alusrc_a)
      2'b00:   X = rs1_fwd;
      2'b01:   X = ex_q.pc;
      2'b10:   X = 32'd0;
      default: X = 32'd0;
    endcase
    if (ex_q.alusrc_b) begin
      Y = ex_q.imm;
    end else begin
      Y = rs2_fwd;
    end
    EX_STORE_DATA = rs2_fwd;
  end

  // Control outputs are masked whenever EX holds a bubble
  always_comb begin
    if (ex_q.valid) begin
      CONTROL      = ex_q.alu_ctrl;
      EX_REG_WRITE = ex_q.reg_write;
      EX_MEM_READ  = ex_q.mem_read;
      EX_MEM_WRITE = ex_q.mem_write;
    end else begin
      CONTROL      = 4'd0;
      EX_REG_WRITE = 1'b0;
      EX_MEM_READ  = 1'b0;
      EX_MEM_WRITE = 1'b0;
    end
  end

  assign EX_VALID        = ex_q.valid;
  assign EX_PC           = ex_q.pc;
  assign EX_RD           = ex_q.rd;
  assign LOAD_USE_HAZARD = load_use;
  assign BUBBLE_CNT      = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_operandos.sv
// Randomized self-checking bench for id_ex_operandos: a behavioural model of
// the instruction held in EX, checked every cycle, plus directed literal checks.
module tb_id_ex_operandos;

  logic        CLK = 1'b0;
  logic        RST, ID_VALID, ID_ALUSRC_B, ID_REG_WRITE, ID_MEM_READ, ID_MEM_WRITE;
  logic [31:0] ID_PC, ID_RS1_DATA, ID_RS2_DATA, ID_IMM;
  logic [4:0]  ID_RS1, ID_RS2, ID_RD;
  logic [3:0]  ID_ALU_CTRL;
  logic [1:0]  ID_ALUSRC_A;
  logic [4:0]  EXMEM_RD, MEMWB_RD;
  logic        EXMEM_REG_WRITE, MEMWB_REG_WRITE, HOLD, FLUSH;
  logic [31:0] EXMEM_RESULT, MEMWB_DATA;
  logic [31:0] X, Y, EX_PC, EX_STORE_DATA;
  logic [3:0]  CONTROL;
  logic [4:0]  EX_RD;
  logic        EX_VALID, EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE, LOAD_USE_HAZARD;
  logic [15:0] BUBBLE_CNT;

  id_ex_operandos dut (
    .CLK(CLK), .RST(RST), .ID_VALID(ID_VALID), .ID_PC(ID_PC),
    .ID_RS1_DATA(ID_RS1_DATA), .ID_RS2_DATA(ID_RS2_DATA), .ID_IMM(ID_IMM),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RD(ID_RD), .ID_ALU_CTRL(ID_ALU_CTRL),
    .ID_ALUSRC_A(ID_ALUSRC_A), .ID_ALUSRC_B(ID_ALUSRC_B), .ID_REG_WRITE(ID_REG_WRITE),
    .ID_MEM_READ(ID_MEM_READ), .ID_MEM_WRITE(ID_MEM_WRITE),
    .EXMEM_RD(EXMEM_RD), .EXMEM_REG_WRITE(EXMEM_REG_WRITE), .EXMEM_RESULT(EXMEM_RESULT),
    .MEMWB_RD(MEMWB_RD), .MEMWB_REG_WRITE(MEMWB_REG_WRITE), .MEMWB_DATA(MEMWB_DATA),
    .HOLD(HOLD), .FLUSH(FLUSH), .X(X), .Y(Y), .CONTROL(CONTROL), .EX_VALID(EX_VALID),
    .EX_PC(EX_PC), .EX_RD(EX_RD), .EX_REG_WRITE(EX_REG_WRITE), .EX_MEM_READ(EX_MEM_READ),
    .EX_MEM_WRITE(EX_MEM_WRITE), .EX_STORE_DATA(EX_STORE_DATA),
    .LOAD_USE_HAZARD(LOAD_USE_HAZARD), .BUBBLE_CNT(BUBBLE_CNT)
  );

  always #5 CLK = ~CLK;

  // Model: the instruction that EX is holding, plus an unbounded bubble count
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  ctrl;
    logic [1:0]  srca;
    logic        srcb, rw, mr, mw;
  } instr_t;

  instr_t m;
  int     cnt;
  int     checks = 0;
  int     errors = 0;
  logic   check_en = 1'b0;
  logic   sat_req = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic exp_hazard();
    return ID_VALID && m.valid && m.mr && (m.rd != 5'd0) &&
           ((ID_RS1 == m.rd) || (ID_RS2 == m.rd));
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] held);
    if (rs == 5'd0) return held;
    if (EXMEM_REG_WRITE && EXMEM_RD == rs) return EXMEM_RESULT;
    if (MEMWB_REG_WRITE && MEMWB_RD == rs) return MEMWB_DATA;
    return held;
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      m   <= '0;
      cnt <= 0;
    end else if (FLUSH) begin
      m   <= '0;
      cnt <= sat_req ? 65532 : cnt;
    end else if (HOLD) begin
      cnt <= sat_req ? 65532 : cnt;
    end else if (exp_hazard()) begin
      m   <= '0;
      cnt <= (sat_req ? 65532 : cnt) + 1;
    end else begin
      m   <= '{valid: ID_VALID, pc: ID_PC, d1: ID_RS1_DATA, d2: ID_RS2_DATA, imm: ID_IMM,
               rs1: ID_RS1, rs2: ID_RS2, rd: ID_RD, ctrl: ID_ALU_CTRL, srca: ID_ALUSRC_A,
               srcb: ID_ALUSRC_B, rw: ID_REG_WRITE, mr: ID_MEM_READ, mw: ID_MEM_WRITE};
      cnt <= sat_req ? 65532 : cnt;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge CLK) begin
    if (check_en) begin
      chk("x", X, (m.srca == 2'b00) ? operand(m.rs1, m.d1) :
                  (m.srca == 2'b01) ? m.pc : 32'd0);
      chk("y", Y, m.srcb ? m.imm : operand(m.rs2, m.d2));
      chk("store_data", EX_STORE_DATA, operand(m.rs2, m.d2));
      chk("control", {28'd0, CONTROL}, {28'd0, m.valid ? m.ctrl : 4'd0});
      chk("ex_valid", {31'd0, EX_VALID}, {31'd0, m.valid});
      chk("ex_pc", EX_PC, m.pc);
      chk("ex_rd", {27'd0, EX_RD}, {27'd0, m.rd});
      chk("ctl_wr_rd_mw", {29'd0, EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE},
          {29'd0, m.valid & m.rw, m.valid & m.mr, m.valid & m.mw});
      chk("hazard", {31'd0, LOAD_USE_HAZARD}, {31'd0, exp_hazard()});
      chk("bubble_cnt", {16'd0, BUBBLE_CNT}, (cnt > 65535) ? 32'h0000FFFF : cnt);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_in();
    RST = 1'b0; HOLD = 1'b0; FLUSH = 1'b0;
    ID_VALID = 1'b0; ID_PC = 32'd0; ID_RS1_DATA = 32'd0; ID_RS2_DATA = 32'd0; ID_IMM = 32'd0;
    ID_RS1 = 5'd0; ID_RS2 = 5'd0; ID_RD = 5'd0; ID_ALU_CTRL = 4'd0; ID_ALUSRC_A = 2'd0;
    ID_ALUSRC_B = 1'b0; ID_REG_WRITE = 1'b0; ID_MEM_READ = 1'b0; ID_MEM_WRITE = 1'b0;
    EXMEM_RD = 5'd0; EXMEM_REG_WRITE = 1'b0; EXMEM_RESULT = 32'd0;
    MEMWB_RD = 5'd0; MEMWB_REG_WRITE = 1'b0; MEMWB_DATA = 32'd0;
  endtask

  task automatic rand_in();
    RST = ($urandom_range(0, 63) == 0);
    FLUSH = ($urandom_range(0, 9) == 0);
    HOLD = ($urandom_range(0, 7) == 0);
    ID_VALID = ($urandom_range(0, 4) != 0);
    ID_PC = $urandom; ID_RS1_DATA = $urandom; ID_RS2_DATA = $urandom; ID_IMM = $urandom;
    ID_RS1 = 5'($urandom_range(0, 3)); ID_RS2 = 5'($urandom_range(0, 3));
    ID_RD = 5'($urandom_range(0, 3)); ID_ALU_CTRL = 4'($urandom);
    ID_ALUSRC_A = 2'($urandom); ID_ALUSRC_B = 1'($urandom);
    ID_REG_WRITE = 1'($urandom); ID_MEM_READ = ($urandom_range(0, 4) < 2);
    ID_MEM_WRITE = 1'($urandom);
    EXMEM_RD = 5'($urandom_range(0, 3)); EXMEM_REG_WRITE = 1'($urandom); EXMEM_RESULT = $urandom;
    MEMWB_RD = 5'($urandom_range(0, 3)); MEMWB_REG_WRITE = 1'($urandom); MEMWB_DATA = $urandom;
  endtask

  initial begin
    clr_in();
    RST = 1'b1;
    repeat (2) tick();

    // Reset while an instruction is presented
    ID_VALID = 1'b1; ID_ALU_CTRL = 4'b0111; RST = 1'b1;
    tick();
    check_en = 1'b1;
    chk("rst_ex_valid", {31'd0, EX_VALID}, 32'd0);
    chk("rst_control", {28'd0, CONTROL}, 32'd0);
    chk("rst_x", X, 32'd0);
    chk("rst_y", Y, 32'd0);
    chk("rst_bubble", {16'd0, BUBBLE_CNT}, 32'd0);

    // ADDI x5, x5, -4
    clr_in();
    ID_VALID = 1'b1; ID_RS1 = 5'd5; ID_RS1_DATA = 32'h10; ID_IMM = 32'hFFFFFFFC;
    ID_ALUSRC_B = 1'b1; ID_REG_WRITE = 1'b1; ID_RD = 5'd5;
    tick();
    chk("addi_x", X, 32'h10);
    chk("addi_y", Y, 32'hFFFFFFFC);
    chk("addi_control", {28'd0, CONTROL}, 32'd0);
    chk("addi_reg_write", {31'd0, EX_REG_WRITE}, 32'd1);

    // Forwarding priority on rs1
    clr_in();
    ID_VALID = 1'b1; ID_RS1 = 5'd7; ID_RS1_DATA = 32'h1234; ID_RD = 5'd8;
    tick();
    ID_VALID = 1'b0; HOLD = 1'b1;
    EXMEM_RD = 5'd7; EXMEM_REG_WRITE = 1'b1; EXMEM_RESULT = 32'h0000AAAA;
    MEMWB_RD = 5'd7; MEMWB_REG_WRITE = 1'b1; MEMWB_DATA = 32'h00005555;
    #1 chk("fwd_exmem", X, 32'h0000AAAA);
    EXMEM_REG_WRITE = 1'b0;
    #1 chk("fwd_memwb", X, 32'h00005555);
    MEMWB_REG_WRITE = 1'b0;
    #1 chk("fwd_none", X, 32'h1234);
    tick();
    clr_in();
    ID_VALID = 1'b1; ID_RS1 = 5'd0;
    tick();
    EXMEM_RD = 5'd0; EXMEM_REG_WRITE = 1'b1; EXMEM_RESULT = 32'hDEAD;
    MEMWB_RD = 5'd0; MEMWB_REG_WRITE = 1'b1; MEMWB_DATA = 32'hBEEF;
    #1 chk("fwd_x0", X, 32'd0);

    // Load-use: LW x3 in EX, consumer reads x3 via rs2
    clr_in();
    ID_VALID = 1'b1; ID_RD = 5'd3; ID_MEM_READ = 1'b1; ID_RS1 = 5'd1; ID_RS2 = 5'd2;
    tick();
    clr_in();
    ID_VALID = 1'b1; ID_RS1 = 5'd9; ID_RS2 = 5'd3;
    #1 chk("lu_hazard", {31'd0, LOAD_USE_HAZARD}, 32'd1);
    tick();
    chk("lu_ex_valid", {31'd0, EX_VALID}, 32'd0);
    chk("lu_mem_read", {31'd0, EX_MEM_READ}, 32'd0);
    chk("lu_bubble", {16'd0, BUBBLE_CNT}, 32'd1);

    // HOLD freezes EX, then FLUSH beats HOLD
    clr_in();
    ID_VALID = 1'b1; ID_PC = 32'h100; ID_RD = 5'd4; ID_ALU_CTRL = 4'b0010; ID_REG_WRITE = 1'b1;
    tick();
    HOLD = 1'b1; ID_PC = 32'h200; ID_RD = 5'd9;
    repeat (3) tick();
    chk("hold_pc", EX_PC, 32'h100);
    chk("hold_rd", {27'd0, EX_RD}, 32'd4);
    chk("hold_control", {28'd0, CONTROL}, 32'd2);
    FLUSH = 1'b1;
    tick();
    chk("flush_ex_valid", {31'd0, EX_VALID}, 32'd0);
    chk("flush_bubble", {16'd0, BUBBLE_CNT}, 32'd1);

    // Saturation: preload the counter near the top, then add bubbles
    clr_in();
    tick();
    sat_req = 1'b1;
    @(negedge CLK);
    #1 force dut.bubble_cnt_q = 16'hFFFC;
    #1 release dut.bubble_cnt_q;
    tick();
    sat_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      clr_in();
      ID_VALID = 1'b1; ID_RD = 5'd3; ID_MEM_READ = 1'b1;
      tick();
      clr_in();
      ID_VALID = 1'b1; ID_RS1 = 5'd3;
      tick();
    end
    chk("sat_bubble", {16'd0, BUBBLE_CNT}, 32'h0000FFFF);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rand_in();
      tick();
    end
    clr_in();
    tick();
    @(negedge CLK);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
